// File: rtl/wb_timeout_slice_if.sv
// Wishbone bus bundle around the timeout slice: upstream slave side (wbs_*) and downstream master side (wbm_*).
// Modport "slave" is the slice's view; "master" is the view of whoever drives wbs_* and answers wbm_*.
interface wb_timeout_slice_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [ADDR_WIDTH-1:0] wbs_adr_i;
    logic [31:0]           wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;

    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [3:0]            wbm_sel_o;
    logic [ADDR_WIDTH-1:0] wbm_adr_o;
    logic [31:0]           wbm_dat_o;
    logic                  wbm_ack_i;
    logic [31:0]           wbm_dat_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_timeout_slice.sv
// Registered Wishbone slice that aborts a downstream request after TIMEOUT_CYCLES and returns ERR_DATA.
// Zero-wait completion acks upstream 2 cycles after the request; one transaction per 3 cycles at best.
module wb_timeout_slice #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    wb_timeout_slice_if.slave        bus,
    output logic                     timeout_o,
    output logic [7:0]               timeout_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // wait_cnt counts completed no-ack cycles, so the last allowed one sees TIMEOUT_CYCLES-1
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state, state_nxt;
    logic [7:0]            wait_cnt, wait_cnt_nxt;
    logic                  cyc_nxt, stb_nxt, we_nxt;
    logic [3:0]            sel_nxt;
    logic [ADDR_WIDTH-1:0] adr_nxt;
    logic [31:0]           wdat_nxt, rdat_nxt;
    logic                  ack_nxt, to_nxt;
    logic [7:0]            cnt_nxt;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state           <= IDLE;
            wait_cnt        <= 8'd0;
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_we_o    <= 1'b0;
            bus.wbm_sel_o   <= 4'd0;
            bus.wbm_adr_o   <= '0;
            bus.wbm_dat_o   <= 32'd0;
            bus.wbs_ack_o   <= 1'b0;
            bus.wbs_dat_o   <= 32'd0;
            timeout_o       <= 1'b0;
            timeout_count_o <= 8'd0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_cnt_nxt;
            bus.wbm_cyc_o   <= cyc_nxt;
            bus.wbm_stb_o   <= stb_nxt;
            bus.wbm_we_o    <= we_nxt;
            bus.wbm_sel_o   <= sel_nxt;
            bus.wbm_adr_o   <= adr_nxt;
            bus.wbm_dat_o   <= wdat_nxt;
            bus.wbs_ack_o   <= ack_nxt;
            bus.wbs_dat_o   <= rdat_nxt;
            timeout_o       <= to_nxt;
            timeout_count_o <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        cyc_nxt      = bus.wbm_cyc_o;
        stb_nxt      = bus.wbm_stb_o;
        we_nxt       = bus.wbm_we_o;
        sel_nxt      = bus.wbm_sel_o;
        adr_nxt      = bus.wbm_adr_o;
        wdat_nxt     = bus.wbm_dat_o;
        rdat_nxt     = bus.wbs_dat_o;
        ack_nxt      = 1'b0;
        to_nxt       = 1'b0;
        cnt_nxt      = timeout_count_o;

        case (state)
            IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i && !bus.wbs_ack_o) begin
                    cyc_nxt      = 1'b1;
                    stb_nxt      = 1'b1;
                    we_nxt       = bus.wbs_we_i;
                    sel_nxt      = bus.wbs_sel_i;
                    adr_nxt      = bus.wbs_adr_i;
                    wdat_nxt     = bus.wbs_dat_i;
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                // An upstream abort outranks both ack and timeout: nobody is left to answer.
                if (!bus.wbs_cyc_i) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (bus.wbm_ack_i) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    rdat_nxt  = bus.wbm_dat_i;
                    ack_nxt   = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    rdat_nxt  = ERR_DATA;
                    ack_nxt   = 1'b1;
                    to_nxt    = 1'b1;
                    cnt_nxt   = (timeout_count_o == 8'hFF) ? 8'hFF : timeout_count_o + 8'd1;
                    state_nxt = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                cyc_nxt   = 1'b0;
                stb_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_timeout_slice.sv
// Directed bench for wb_timeout_slice: per-cycle vector table plus hand-written timeout/abort/saturation sequences.
module tb_wb_timeout_slice;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic       clk;
    logic       rst_n;
    logic       timeout;
    logic [7:0] tcnt;

    wb_timeout_slice_if #(.ADDR_WIDTH(8)) bus ();

    wb_timeout_slice #(
        .ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(16),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst_n),
        .bus(bus.slave),
        .timeout_o(timeout),
        .timeout_count_o(tcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic        ack;
        logic [31:0] rdat;
        logic        e_ack;
        logic [31:0] e_dat;
        logic        e_mcyc;
        logic        e_mstb;
        logic        e_mwe;
        logic [3:0]  e_msel;
        logic [7:0]  e_madr;
        logic [31:0] e_mdat;
        logic        e_to;
        logic [7:0]  e_tcnt;
    } vec_t;

    vec_t vec [15];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [3:0] sel, input logic [7:0] adr, input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbm_ack_i = 1'b0;
    endtask

    task automatic drop_req();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbm_ack_i = 1'b0;
    endtask

    function automatic logic [88:0] outv();
        return {bus.wbs_ack_o, bus.wbs_dat_o, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
                bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o, timeout, tcnt};
    endfunction

    initial begin
        int n;
        int pulses;
        int budget;
        logic [7:0] exp_cnt;
        logic [88:0] expv;

        //          rst cyc stb we sel    adr    wdat           ack rdat             e_ack e_dat          mcyc mstb mwe msel  madr   mdat           to tcnt
        vec[0]  = '{L, H, H, H, 4'hF, 8'h55, 32'hFFFF_FFFF, H, 32'hABCD_0000,   L, 32'h0,          L, L, L, 4'h0, 8'h00, 32'h0,          L, 8'd0};
        vec[1]  = '{H, L, L, L, 4'h0, 8'h00, 32'h0,         L, 32'h0,           L, 32'h0,          L, L, L, 4'h0, 8'h00, 32'h0,          L, 8'd0};
        vec[2]  = '{H, H, H, L, 4'hF, 8'h10, 32'h0,         L, 32'h0,           L, 32'h0,          H, H, L, 4'hF, 8'h10, 32'h0,          L, 8'd0};
        vec[3]  = '{H, H, H, L, 4'hF, 8'h10, 32'h0,         H, 32'h1234_5678,   H, 32'h1234_5678,  L, L, L, 4'hF, 8'h10, 32'h0,          L, 8'd0};
        vec[4]  = '{H, H, H, L, 4'hF, 8'h10, 32'h0,         H, 32'hFFFF_0000,   L, 32'h1234_5678,  L, L, L, 4'hF, 8'h10, 32'h0,          L, 8'd0};
        vec[5]  = '{H, L, L, L, 4'h0, 8'h00, 32'h0,         H, 32'h0BAD_0BAD,   L, 32'h1234_5678,  L, L, L, 4'hF, 8'h10, 32'h0,          L, 8'd0};
        vec[6]  = '{H, H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 32'h0,           L, 32'h1234_5678,  H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 8'd0};
        vec[7]  = '{H, H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 32'h0,           L, 32'h1234_5678,  H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 8'd0};
        vec[8]  = '{H, H, H, L, 4'h0, 8'h99, 32'h0,         L, 32'h0,           L, 32'h1234_5678,  H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 8'd0};
        vec[9]  = '{H, H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 32'h0,           L, 32'h1234_5678,  H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 8'd0};
        vec[10] = '{H, H, H, H, 4'h3, 8'h20, 32'hA5A5_A5A5, H, 32'h0000_0077,   H, 32'h0000_0077,  L, L, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 8'd0};
        vec[11] = '{H, L, L, L, 4'h0, 8'h00, 32'h0,         L, 32'h0,           L, 32'h0000_0077,  L, L, H, 4'h3, 8'h20, 32'hA5A5_A5A5, L, 8'd0};
        vec[12] = '{H, H, H, L, 4'hF, 8'h33, 32'h1111_2222, L, 32'h0,           L, 32'h0000_0077,  H, H, L, 4'hF, 8'h33, 32'h1111_2222, L, 8'd0};
        vec[13] = '{L, H, H, L, 4'hF, 8'h33, 32'h1111_2222, H, 32'h0000_5555,   L, 32'h0,          L, L, L, 4'h0, 8'h00, 32'h0,          L, 8'd0};
        vec[14] = '{H, L, L, L, 4'h0, 8'h00, 32'h0,         L, 32'h0,           L, 32'h0,          L, L, L, 4'h0, 8'h00, 32'h0,          L, 8'd0};

        rst_n = 1'b0;
        drop_req();
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 8'h00;
        bus.wbs_dat_i = 32'h0;
        bus.wbm_dat_i = 32'h0;

        for (int i = 0; i < 15; i++) begin
            rst_n         = vec[i].rst;
            bus.wbs_cyc_i = vec[i].cyc;
            bus.wbs_stb_i = vec[i].stb;
            bus.wbs_we_i  = vec[i].we;
            bus.wbs_sel_i = vec[i].sel;
            bus.wbs_adr_i = vec[i].adr;
            bus.wbs_dat_i = vec[i].wdat;
            bus.wbm_ack_i = vec[i].ack;
            bus.wbm_dat_i = vec[i].rdat;
            tick();
            expv = {vec[i].e_ack, vec[i].e_dat, vec[i].e_mcyc, vec[i].e_mstb, vec[i].e_mwe,
                    vec[i].e_msel, vec[i].e_madr, vec[i].e_mdat, vec[i].e_to, vec[i].e_tcnt};
            chk($sformatf("vec%0d", i), outv(), expv);
        end

        // Silent slave: strobe must stay up exactly 16 cycles, then error data and one pulse.
        set_req(1'b0, 4'hF, 8'h40, 32'h0);
        tick();
        n = 0;
        pulses = 0;
        while (bus.wbm_stb_o && n < 40) begin
            n++;
            if (timeout) pulses++;
            tick();
        end
        chk("to_stb_cycles", n, 16);
        chk("to_no_early_pulse", pulses, 0);
        chk("to_resp", {bus.wbs_ack_o, bus.wbs_dat_o, timeout, tcnt}, {1'b1, 32'hDEAD_BEEF, 1'b1, 8'd1});
        drop_req();
        tick();
        chk("to_pulse_end", {bus.wbs_ack_o, timeout, tcnt}, {1'b0, 1'b0, 8'd1});

        // Ack arriving in the 16th strobe cycle beats the timeout.
        set_req(1'b0, 4'hF, 8'h41, 32'h0);
        tick();
        for (int k = 1; k <= 15; k++) tick();
        chk("ack16_stb_still", bus.wbm_stb_o, 1'b1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h0000_0001;
        tick();
        chk("ack16_resp", {bus.wbs_ack_o, bus.wbs_dat_o, timeout, tcnt}, {1'b1, 32'h0000_0001, 1'b0, 8'd1});
        drop_req();
        tick();
        chk("ack16_after", {bus.wbs_ack_o, timeout, tcnt}, {1'b0, 1'b0, 8'd1});

        // Upstream drops cyc in the 3rd REQ cycle, then a stray late ack.
        set_req(1'b1, 4'hC, 8'h50, 32'h0001_2345);
        tick();
        tick();
        tick();
        drop_req();
        tick();
        chk("abort_drop", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbs_ack_o, timeout}, 4'b0000);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h0000_CAFE;
        tick();
        chk("abort_late_ack", {bus.wbs_ack_o, bus.wbs_dat_o, timeout, tcnt}, {1'b0, 32'h0000_0001, 1'b0, 8'd1});
        set_req(1'b0, 4'hF, 8'h60, 32'h0);
        tick();
        chk("abort_idle", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o}, {1'b1, 1'b1, 8'h60});
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h0000_600D;
        tick();
        chk("abort_next_ack", {bus.wbs_ack_o, bus.wbs_dat_o}, {1'b1, 32'h0000_600D});
        drop_req();
        tick();

        // 300 back-to-back timeouts with the request held: counter saturates at 255.
        set_req(1'b0, 4'hF, 8'h70, 32'h0);
        pulses  = 0;
        budget  = 0;
        exp_cnt = 8'd1;
        while (pulses < 300 && budget < 300 * 20) begin
            tick();
            budget++;
            if (timeout) begin
                pulses++;
                exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
                chk("sat_count", tcnt, exp_cnt);
            end
        end
        chk("sat_pulses", pulses, 300);
        chk("sat_final", tcnt, 8'hFF);
        tick();
        tick();
        tick();
        chk("sat_midreq", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b11);
        rst_n = 1'b0;
        tick();
        chk("rst_midreq", outv(), 89'd0);
        rst_n = 1'b1;
        drop_req();
        tick();
        chk("rst_after", outv(), 89'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_timeout_slice.md
WB_TIMEOUT_SLICE -- requirements
Module: wb_timeout_slice

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width of the address on both ports.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, range 2..255, the number of cycles a downstream request is held before it is aborted.
REQ-003 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, the read data returned on timeout.
REQ-004 SHALL use one clock and a synchronous, active-low reset, as follows:
  wb_clk_i  in  1  clock; all state changes on its rising edge.
  wb_rst_i  in  1  synchronous active-low reset (0 = reset).
REQ-005 SHALL have the following upstream slave ports, driven by the bridge's downward-facing port:
  wbs_cyc_i  in  1  cycle.
  wbs_stb_i  in  1  strobe.
  wbs_we_i  in  1  write enable.
  wbs_sel_i  in  4  byte select.
  wbs_adr_i  in  ADDR_WIDTH  address.
  wbs_dat_i  in  32  write data.
  wbs_ack_o  out  1  acknowledge.
  wbs_dat_o  out  32  read data.
REQ-006 SHALL have the following downstream master ports:
  wbm_cyc_o  out  1  cycle.
  wbm_stb_o  out  1  strobe.
  wbm_we_o  out  1  write enable.
  wbm_sel_o  out  4  byte select.
  wbm_adr_o  out  ADDR_WIDTH  address.
  wbm_dat_o  out  32  write data.
  wbm_ack_i  in  1  acknowledge.
  wbm_dat_i  in  32  read data.
REQ-007 SHALL have the following status ports:
  timeout_o  out  1  one-cycle pulse per timed-out transaction.
  timeout_count_o  out  8  saturating count of timeouts.

Function
REQ-008 SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-009 SHALL implement the FSM states IDLE, REQ and RESP.
REQ-010 IDLE: when wbs_cyc_i=1, wbs_stb_i=1 and wbs_ack_o=0, the block SHALL capture adr, dat, sel and we into the downstream registers, set wbm_cyc_o=wbm_stb_o=1, clear the wait counter and go to REQ.
REQ-011 REQ: the wbm_* request fields SHALL remain stable, and the wait counter SHALL increment each cycle that wbm_ack_i=0.
REQ-012 REQ, wbm_ack_i=1: the block SHALL register wbm_dat_i into wbs_dat_o (for reads and writes alike), clear wbm_cyc_o/wbm_stb_o, set wbs_ack_o=1 and go to RESP.
REQ-013 REQ, timeout: when wbm_stb_o has been high for TIMEOUT_CYCLES cycles with no ack, the block SHALL clear wbm_cyc_o/wbm_stb_o, load wbs_dat_o=ERR_DATA, set wbs_ack_o=1, pulse timeout_o for 1 cycle, increment timeout_count_o (saturating at 255), and go to RESP.
REQ-014 If ack and the timeout condition occur in the same cycle, ack SHALL win: normal data is returned and there is no timeout pulse or count.
REQ-015 RESP: wbs_ack_o SHALL be high for exactly one cycle, and the block SHALL then return to IDLE; any new request SHALL be accepted no earlier than the IDLE cycle that follows.
REQ-016 Upstream abort: if wbs_cyc_i=0 in REQ, the block SHALL clear wbm_cyc_o/wbm_stb_o next edge and return to IDLE with no wbs_ack_o and no timeout.
REQ-017 wbm_ack_i asserted in IDLE or RESP SHALL be ignored and SHALL leave wbs_dat_o unchanged.
REQ-018 wbs_dat_o SHALL hold its last value until the next completion.
REQ-019 Latency: with a zero-wait slave (ack in the first wbm_stb_o cycle), wbs_ack_o SHALL rise 2 cycles after the request is sampled in IDLE.
REQ-020 Throughput: at most one transaction per 3 cycles.

Reset
REQ-021 While wb_rst_i=0 at a rising edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (wbs_ack_o, wbs_dat_o, wbm_*, timeout_o, timeout_count_o, wait counter).
REQ-022 Reset asserted mid-transaction SHALL drop wbm_cyc_o/wbm_stb_o on that edge with no ack and no timeout.
REQ-023 Inputs sampled during reset SHALL be ignored.

Verification
REQ-024 Zero-wait read: wbs request with adr=8'h10, and slave acks at the first wbm_stb_o cycle with dat=32'h1234_5678 -> wbs_ack_o high 1 cycle, 2 cycles after the request, wbs_dat_o=32'h1234_5678.
REQ-025 Write with 3 wait states: we=1, sel=4'b0011, dat=32'hA5A5_A5A5 -> wbm_* fields stable for 4 cycles, one wbs_ack_o, timeout_count_o=0.
REQ-026 Silent slave, TIMEOUT_CYCLES=16 -> wbm_stb_o high exactly 16 cycles, then wbs_ack_o with wbs_dat_o=32'hDEAD_BEEF, timeout_o pulses once, timeout_count_o=1.
REQ-027 Ack on the 16th cycle of wbm_stb_o with dat=32'h0000_0001 -> normal data returned, no timeout_o pulse.
REQ-028 wbs_cyc_i dropped in the 3rd REQ cycle, then a late wbm_ack_i -> no wbs_ack_o, wbs_dat_o unchanged, FSM back in IDLE.
REQ-029 300 back-to-back timeouts, then wb_rst_i=0 mid-REQ -> timeout_count_o saturates at 255; after reset all outputs are 0.
